// File: rtl/door_lock_if.sv
// Key-event and status bundle between the keyboard/game side and the door lock controller.
// The master drives game state and key strobes; the slave (lock controller) reports status.
interface door_lock_if;
  logic [3:0] state;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_enter;
  logic       key_clear;
  logic       isLocked;
  logic       unlock_pulse;
  logic       lockout;
  logic [3:0] fail_cnt;
  logic [3:0] digit_cnt;

  modport master (
    output state, key_valid, key_code, key_enter, key_clear,
    input  isLocked, unlock_pulse, lockout, fail_cnt, digit_cnt
  );

  modport slave (
    input  state, key_valid, key_code, key_enter, key_clear,
    output isLocked, unlock_pulse, lockout, fail_cnt, digit_cnt
  );
endinterface

// File: rtl/door_lock_ctrl.sv
// Code-entry lock for the STAGE1 door: buffers digit keys, checks them on ENTER,
// opens the door on a match and imposes a timed lockout after repeated wrong codes.
module door_lock_ctrl #(
  parameter int unsigned           CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0] CODE         = 16'h1234,
  parameter int unsigned           MAX_FAIL     = 3,
  parameter int unsigned           LOCKOUT_CYC  = 100000000,
  parameter logic [3:0]            ACTIVE_STATE = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  door_lock_if.slave  io
);

  localparam int unsigned   BW     = 4 * CODE_LEN;
  localparam int unsigned   TW     = $clog2(LOCKOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [3:0]    LEN4   = 4'(CODE_LEN);
  localparam logic [3:0]    MAXF4  = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_LOCKOUT
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    digit_q, digit_d;
  logic [3:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          locked_q, locked_d;
  logic          pulse_q, pulse_d;
  logic          lockout_q, lockout_d;

  logic          active;
  logic          pass;
  logic [3:0]    fail_inc;

  assign active   = (io.state == ACTIVE_STATE);
  assign pass     = (digit_q == LEN4) && (buf_q == CODE);
  assign fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    fsm_d     = fsm_q;
    buf_d     = buf_q;
    digit_d   = digit_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    locked_d  = 1'b1;
    pulse_d   = 1'b0;
    lockout_d = 1'b0;

    if (!active) begin
      fsm_d   = S_IDLE;
      buf_d   = '0;
      digit_d = '0;
      fail_d  = '0;
      timer_d = '0;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          fsm_d   = S_ENTRY;
          buf_d   = '0;
          digit_d = '0;
          fail_d  = '0;
          timer_d = '0;
        end
        S_ENTRY: begin
          if (io.key_clear) begin
            buf_d   = '0;
            digit_d = '0;
          end else if (io.key_enter) begin
            fsm_d = S_CHECK;
          end else if (io.key_valid && io.key_code <= 4'd9 && digit_q < LEN4) begin
            buf_d   = (buf_q << 4) | BW'(io.key_code);
            digit_d = digit_q + 4'd1;
          end
        end
        S_CHECK: begin
          if (pass) begin
            fsm_d = S_OPEN;
          end else begin
            fail_d  = fail_inc;
            buf_d   = '0;
            digit_d = '0;
            if (fail_inc >= MAXF4) begin
              fsm_d     = S_LOCKOUT;
              lockout_d = 1'b1;
              timer_d   = '0;
            end else begin
              fsm_d = S_ENTRY;
            end
          end
        end
        S_OPEN: begin
          // locked_q is still high only in the first OPEN cycle, which yields the single pulse
          locked_d = 1'b0;
          pulse_d  = locked_q;
        end
        S_LOCKOUT: begin
          if (timer_q == T_LAST) begin
            fsm_d   = S_ENTRY;
            fail_d  = '0;
            timer_d = '0;
          end else begin
            timer_d   = timer_q + T_ONE;
            lockout_d = 1'b1;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    if (rst) begin
      fsm_q     <= S_IDLE;
      buf_q     <= '0;
      digit_q   <= '0;
      fail_q    <= '0;
      timer_q   <= '0;
      locked_q  <= 1'b1;
      pulse_q   <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      buf_q     <= buf_d;
      digit_q   <= digit_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      locked_q  <= locked_d;
      pulse_q   <= pulse_d;
      lockout_q <= lockout_d;
    end
  end

  assign io.isLocked     = locked_q;
  assign io.unlock_pulse = pulse_q;
  assign io.lockout      = lockout_q;
  assign io.fail_cnt     = fail_q;
  assign io.digit_cnt    = digit_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Self-checking bench for door_lock_ctrl: vector table, directed corner sequences and
// randomized traffic compared every cycle against a digit-queue reference model.
module tb_door_lock_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  door_lock_if ifc ();

  door_lock_ctrl #(
    .CODE_LEN    (4),
    .CODE        (16'h1234),
    .MAX_FAIL    (3),
    .LOCKOUT_CYC (8),
    .ACTIVE_STATE(4'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the entered code as a queue of digits plus a few status flags.
  bit m_idle      = 1'b1;
  bit m_checking  = 1'b0;
  bit m_open      = 1'b0;
  bit m_shown     = 1'b0;
  int m_lock_left = 0;
  int m_fails     = 0;
  int m_digits[$];
  bit e_locked    = 1'b1;
  bit e_pulse     = 1'b0;

  typedef struct {
    bit          r;
    logic [3:0]  st;
    bit          kv;
    logic [3:0]  kc;
    bit          ke;
    bit          kcl;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] dut_outs();
    return {ifc.isLocked, ifc.unlock_pulse, ifc.lockout, ifc.fail_cnt, ifc.digit_cnt};
  endfunction

  function automatic logic [10:0] model_outs();
    return {e_locked, e_pulse, (m_lock_left > 0), 4'(m_fails), 4'(m_digits.size())};
  endfunction

  function automatic void model_step(bit r, logic [3:0] st, bit kv, logic [3:0] kc, bit ke, bit kcl);
    int value;
    e_locked = 1'b1;
    e_pulse  = 1'b0;
    if (r || st != 4'd2) begin
      m_idle = 1'b1; m_checking = 1'b0; m_open = 1'b0; m_shown = 1'b0;
      m_lock_left = 0; m_fails = 0; m_digits.delete();
    end else if (m_idle) begin
      m_idle = 1'b0; m_fails = 0; m_digits.delete();
    end else if (m_checking) begin
      m_checking = 1'b0;
      value = 0;
      foreach (m_digits[i]) value = value * 16 + m_digits[i];
      if (m_digits.size() == 4 && value == 'h1234) begin
        m_open = 1'b1;
      end else begin
        m_fails = (m_fails < 15) ? m_fails + 1 : 15;
        m_digits.delete();
        if (m_fails >= 3) m_lock_left = 8;
      end
    end else if (m_open) begin
      e_locked = 1'b0;
      e_pulse  = !m_shown;
      m_shown  = 1'b1;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (kcl) begin
      m_digits.delete();
    end else if (ke) begin
      m_checking = 1'b1;
    end else if (kv && kc <= 4'd9 && m_digits.size() < 4) begin
      m_digits.push_back(int'(kc));
    end
  endfunction

  task automatic step(input bit r, input logic [3:0] st, input bit kv, input logic [3:0] kc,
                      input bit ke, input bit kcl);
    rst           = r;
    ifc.state     = st;
    ifc.key_valid = kv;
    ifc.key_code  = kc;
    ifc.key_enter = ke;
    ifc.key_clear = kcl;
    @(posedge clk);
    model_step(r, st, kv, kc, ke, kcl);
    #1;
    check("model", 32'(dut_outs()), 32'(model_outs()));
    ifc.key_valid = 1'b0;
    ifc.key_enter = 1'b0;
    ifc.key_clear = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 4'd2, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic enter();
    step(1'b0, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_entry();
    step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic wrong_code();
    key(4'd1); key(4'd2); key(4'd3); key(4'd5); enter(); idle();
  endtask

  function automatic void add(bit r, logic [3:0] st, bit kv, logic [3:0] kc, bit ke, bit kcl,
                              bit lk, bit p, bit lo, logic [3:0] f, logic [3:0] d);
    vec_t v;
    v.r = r; v.st = st; v.kv = kv; v.kc = kc; v.ke = ke; v.kcl = kcl;
    v.exp = {lk, p, lo, f, d};
    tbl.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_cnt;
    bit seen;
    bit r, kv, ke, kcl;
    logic [3:0] st, kc;
    int sel;

    // Unlock path, OPEN ignoring keys, stage exit, clear-beats-enter, fail kept until stage exit.
    add(1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0,  1, 0, 0, 0, 1);
    add(0, 2, 1, 2, 0, 0,  1, 0, 0, 0, 2);
    add(0, 2, 1, 3, 0, 0,  1, 0, 0, 0, 3);
    add(0, 2, 1, 4, 0, 0,  1, 0, 0, 0, 4);
    add(0, 2, 0, 0, 1, 0,  1, 0, 0, 0, 4);
    add(0, 2, 0, 0, 0, 0,  1, 0, 0, 0, 4);
    add(0, 2, 0, 0, 0, 0,  0, 1, 0, 0, 4);
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 0, 4);
    add(0, 2, 1, 5, 0, 0,  0, 0, 0, 0, 4);
    add(0, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(0, 2, 1, 1, 0, 0,  1, 0, 0, 0, 1);
    add(0, 2, 1, 2, 0, 0,  1, 0, 0, 0, 2);
    add(0, 2, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    add(0, 2, 1, 7, 0, 0,  1, 0, 0, 0, 1);
    add(0, 2, 0, 0, 1, 0,  1, 0, 0, 0, 1);
    add(0, 2, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    add(0, 2, 1, 1, 0, 0,  1, 0, 0, 1, 1);
    add(0, 2, 1, 2, 0, 0,  1, 0, 0, 1, 2);
    add(0, 2, 1, 3, 0, 0,  1, 0, 0, 1, 3);
    add(0, 2, 1, 4, 0, 0,  1, 0, 0, 1, 4);
    add(0, 2, 0, 0, 1, 0,  1, 0, 0, 1, 4);
    add(0, 2, 0, 0, 0, 0,  1, 0, 0, 1, 4);
    add(0, 2, 0, 0, 0, 0,  0, 1, 0, 1, 4);
    add(0, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].st, tbl[i].kv, tbl[i].kc, tbl[i].ke, tbl[i].kcl);
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(tbl[i].exp));
    end

    // Three wrong codes lead to an 8-cycle lockout during which keys are ignored.
    reset_entry();
    for (int a = 0; a < 3; a++) begin
      wrong_code();
      check("fail_cnt_step", 32'(ifc.fail_cnt), 32'(a + 1));
      check("digit_cleared", 32'(ifc.digit_cnt), 32'd0);
      check("still_locked", 32'(ifc.isLocked), 32'd1);
    end
    check("lockout_on", 32'(ifc.lockout), 32'd1);
    lo_cnt = 1;
    for (int c = 0; c < 20; c++) begin
      key(4'd7);
      if (ifc.lockout) lo_cnt++;
      else break;
    end
    check("lockout_len", 32'(lo_cnt), 32'd8);
    check("lockout_fail_clr", 32'(ifc.fail_cnt), 32'd0);
    check("lockout_keys_drop", 32'(ifc.digit_cnt), 32'd0);
    key(4'd7);
    check("entry_after_lockout", 32'(ifc.digit_cnt), 32'd1);

    // Fifth digit dropped, key during CHECK dropped, short code fails, codes >9 ignored.
    reset_entry();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd9);
    check("extra_digit_drop", 32'(ifc.digit_cnt), 32'd4);
    enter();
    key(4'd9);
    check("check_cycle_locked", 32'(ifc.isLocked), 32'd1);
    idle();
    check("unlock_5digit", {30'd0, ifc.isLocked, ifc.unlock_pulse}, 32'b01);
    step(1'b0, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    key(4'd1); key(4'd2); key(4'd3); enter(); idle();
    check("short_code_fail", 32'(ifc.fail_cnt), 32'd1);
    key(4'd1); key(4'd12); key(4'd2); key(4'd12); key(4'd3); key(4'd4);
    check("code12_ignored", 32'(ifc.digit_cnt), 32'd4);
    enter(); idle(); idle();
    check("unlock_after_12", {30'd0, ifc.isLocked, ifc.unlock_pulse}, 32'b01);

    // Leaving the stage relocks and zeroes counters; reset aborts a lockout.
    step(1'b0, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
    check("relock_on_exit", 32'(ifc.isLocked), 32'd1);
    check("exit_counters", {24'd0, ifc.fail_cnt, ifc.digit_cnt}, 32'd0);
    idle(); idle();
    wrong_code(); wrong_code(); wrong_code();
    check("lockout_before_rst", 32'(ifc.lockout), 32'd1);
    step(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
    check("rst_aborts_lockout", {28'd0, ifc.lockout, ifc.fail_cnt[2:0]}, 32'd0);

    // Outside STAGE1 the correct code never opens the door.
    step(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 4'd0, 1'b1, 4'(k), 1'b0, 1'b0);
      seen |= ifc.unlock_pulse | !ifc.isLocked;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'd0, 1'b0, 4'd0, k == 0, 1'b0);
      seen |= ifc.unlock_pulse | !ifc.isLocked;
    end
    check("no_unlock_outside", 32'(seen), 32'd0);

    // Randomized traffic, biased towards the correct next digit so unlocks and lockouts both occur.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      sel = $urandom_range(0, 99);
      kv = 1'b0; ke = 1'b0; kcl = 1'b0; kc = 4'd0;
      if (sel < 3) kcl = 1'b1;
      else if (sel < 15) ke = 1'b1;
      else if (sel < 70) begin
        kv = 1'b1;
        kc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_digits.size() + 1);
      end
      step(r, st, kv, kc, ke, kcl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
